sys_bus_interconnect: RTL and testbench
=======================================

SYS_BUS_INTERCONNECT -- requirements
Module: sys_bus_interconnect

Interface
REQ-001 Parameters SHALL be as follows:
- SYS_DW, default 32: data width.
- SYS_AW, default 32: address width.
- SYS_SW, default SYS_DW/8: byte-select width.
- SLV_LOG2, default 3: log2 of slave count N.
- SEL_LSB, default 20: LSB of the slave-index field in the address.
- SLV_MASK, default N bits all 1: bit i set means slave i is mapped.
- TMO_CYC, default 16: timeout in cycles.
REQ-002 Ports SHALL be as follows:
- sys_clk_i  in  1  clock.
- sys_rst_i  in  1  reset.
- sys_addr_i  in  SYS_AW  upstream address.
- sys_wdata_i  in  SYS_DW  upstream write data.
- sys_sel_i  in  SYS_SW  upstream byte select.
- sys_wen_i  in  1  upstream write strobe.
- sys_ren_i  in  1  upstream read strobe.
- sys_rdata_o  out  SYS_DW  read data.
- sys_err_o  out  1  error.
- sys_ack_o  out  1  acknowledge.
- slv_addr_o  out  SYS_AW  address to all slaves.
- slv_wdata_o  out  SYS_DW  write data to all slaves.
- slv_sel_o  out  SYS_SW  byte select to all slaves.
- slv_wen_o  out  N  per-slave write strobe.
- slv_ren_o  out  N  per-slave read strobe.
- slv_rdata_i  in  N*SYS_DW  slave i occupies bits [i*SYS_DW +: SYS_DW].
- slv_err_i  in  N  per-slave error.
- slv_ack_i  in  N  per-slave acknowledge.
REQ-003 One clock (sys_clk_i); reset sys_rst_i SHALL be synchronous and active-high.

Function
REQ-004 The block SHALL sit downstream of the AXI4-Lite slave, decode one upstream sys-bus transaction at a time and route it to one of N slaves.
REQ-005 The slave index SHALL be sys_addr_i[SEL_LSB +: SLV_LOG2]; slv_addr_o SHALL carry the full unmodified address.
REQ-006 The FSM SHALL have the states IDLE, BUSY and RESP.
REQ-007 In IDLE, on sys_wen_i or sys_ren_i, the block SHALL latch address, wdata, sel, index and direction; if both strobes are high, write SHALL win and ren SHALL be ignored.
REQ-008 A mapped request accepted at cycle T SHALL assert slv_wen_o[idx] or slv_ren_o[idx] for exactly one cycle at T+1 and enter BUSY.
REQ-009 An unmapped request (SLV_MASK[idx]==0) SHALL generate no slave strobe; the block SHALL enter RESP and pulse sys_ack_o=1, sys_err_o=1, sys_rdata_o=0 at T+1.
REQ-010 In BUSY, the first cycle with slv_ack_i[idx] or slv_err_i[idx] high (including the strobe cycle itself) SHALL register the response.
REQ-011 The registered response SHALL be sys_rdata_o = slave idx data (0 for writes), sys_err_o = slv_err_i[idx] and sys_ack_o=1 for one cycle, then return to IDLE.
REQ-012 Acks or errors from non-selected slaves, and from the selected slave outside BUSY, SHALL be ignored.
REQ-013 Upstream strobes arriving while in BUSY or RESP SHALL be dropped, with no queueing and no ack.
REQ-014 sys_ack_o SHALL be high for exactly one cycle per accepted request; sys_err_o and sys_rdata_o SHALL be 0 whenever sys_ack_o is 0.
REQ-015 slv_addr_o, slv_wdata_o and slv_sel_o SHALL hold their latched values until the next accepted request.
REQ-016 A back-to-back request SHALL be accepted in the cycle after sys_ack_o.

Reset
REQ-017 While sys_rst_i=1, the FSM SHALL be in IDLE and every output SHALL be 0 (slv_wen_o, slv_ren_o, sys_ack_o, sys_err_o, sys_rdata_o, slv_addr_o, slv_wdata_o, slv_sel_o).
REQ-018 Reset during BUSY SHALL abort the transaction with no ack; a late slave ack after reset release SHALL be ignored.

Configuration
REQ-019 With SYS_BUS_TIMEOUT_EN defined, a counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-020 With SYS_BUS_TIMEOUT_EN defined, reaching TMO_CYC without a slave response SHALL emit sys_ack_o=1, sys_err_o=1, sys_rdata_o=0 and return to IDLE.
REQ-021 With SYS_BUS_TIMEOUT_EN defined, a slave response in the same cycle as the timeout SHALL take priority.
REQ-022 Without SYS_BUS_TIMEOUT_EN, no counter SHALL exist and BUSY SHALL wait indefinitely.

Verification
REQ-023 Write to 0x0030_0004 with data 0xDEADBEEF, slave 3 acking 2 cycles after its strobe -> slv_wen_o=8'h08 for 1 cycle, slv_wdata_o=0xDEADBEEF, sys_ack_o=1 with sys_err_o=0 one cycle after the slave ack.
REQ-024 Read from 0x0050_0000 with slave 5 acking combinationally in its strobe cycle, data 0x12345678 -> sys_rdata_o=0x12345678 and sys_ack_o=1 at T+2.
REQ-025 SLV_MASK=8'h7F, read from 0x0070_0000 -> no slv_ren_o, sys_ack_o=1 with sys_err_o=1 and sys_rdata_o=0 at T+1.
REQ-026 With SYS_BUS_TIMEOUT_EN and TMO_CYC=16, a read to a silent slave 1 -> ack with err exactly 16 BUSY cycles after entry; a slave-1 ack at cycle 20 is ignored.
REQ-027 Slave 2 busy while slave 4 asserts ack, and a second upstream wen during BUSY -> both ignored, single sys_ack_o pulse.
REQ-028 sys_rst_i asserted mid-BUSY for 1 cycle -> all outputs 0, no sys_ack_o, the next request is served normally.

Source files
------------

// File: rtl/sys_bus_interconnect.sv
// sys_bus_interconnect
//   Routes one upstream sys-bus transaction at a time to one of N = 2**SLV_LOG2
//   slaves. The slave index is addr[SEL_LSB +: SLV_LOG2]. Unmapped slaves
//   (SLV_MASK bit clear) are answered locally with an error response.
//
//   Optional feature: define SYS_BUS_TIMEOUT_EN to add a BUSY-state timeout
//   of TMO_CYC cycles that answers with an error. Without it, BUSY waits
//   indefinitely.
//
// Ports
//   sys_clk_i, sys_rst_i      clock, synchronous active-high reset
//   sys_addr_i/wdata_i/sel_i  upstream request fields
//   sys_wen_i, sys_ren_i      upstream write / read strobes (write wins)
//   sys_rdata_o/err_o/ack_o   upstream response, valid for one cycle
//   slv_addr_o/wdata_o/sel_o  latched request fields shared by all slaves
//   slv_wen_o, slv_ren_o      per-slave one-cycle strobes
//   slv_rdata_i               slave i at [i*SYS_DW +: SYS_DW]
//   slv_err_i, slv_ack_i      per-slave response flags
module sys_bus_interconnect #(
  parameter int unsigned SYS_DW   = 32,
  parameter int unsigned SYS_AW   = 32,
  parameter int unsigned SYS_SW   = SYS_DW / 8,
  parameter int unsigned SLV_LOG2 = 3,
  localparam int unsigned N       = 2 ** SLV_LOG2,
  parameter int unsigned SEL_LSB  = 20,
  parameter logic [N-1:0] SLV_MASK = '1,
  parameter int unsigned TMO_CYC  = 16
) (
  input  logic                sys_clk_i,
  input  logic                sys_rst_i,
  input  logic [SYS_AW-1:0]   sys_addr_i,
  input  logic [SYS_DW-1:0]   sys_wdata_i,
  input  logic [SYS_SW-1:0]   sys_sel_i,
  input  logic                sys_wen_i,
  input  logic                sys_ren_i,
  output logic [SYS_DW-1:0]   sys_rdata_o,
  output logic                sys_err_o,
  output logic                sys_ack_o,
  output logic [SYS_AW-1:0]   slv_addr_o,
  output logic [SYS_DW-1:0]   slv_wdata_o,
  output logic [SYS_SW-1:0]   slv_sel_o,
  output logic [N-1:0]        slv_wen_o,
  output logic [N-1:0]        slv_ren_o,
  input  logic [N*SYS_DW-1:0] slv_rdata_i,
  input  logic [N-1:0]        slv_err_i,
  input  logic [N-1:0]        slv_ack_i
);

  if (TMO_CYC < 1) begin : g_tmo_chk
    $error("TMO_CYC must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t              state;
  logic [SLV_LOG2-1:0] idx;
  logic                is_wr;
  logic [SLV_LOG2-1:0] req_idx;
  logic [SYS_DW-1:0]   sel_rdata;
  logic                sel_ack;
  logic                sel_err;

`ifdef SYS_BUS_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TMO_CYC + 1);
  logic [CW-1:0] cnt;
`endif

  always_comb begin
    req_idx   = sys_addr_i[SEL_LSB +: SLV_LOG2];
    sel_rdata = slv_rdata_i[idx*SYS_DW +: SYS_DW];
    sel_ack   = slv_ack_i[idx];
    sel_err   = slv_err_i[idx];
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state       <= IDLE;
      idx         <= '0;
      is_wr       <= 1'b0;
      slv_addr_o  <= '0;
      slv_wdata_o <= '0;
      slv_sel_o   <= '0;
      slv_wen_o   <= '0;
      slv_ren_o   <= '0;
      sys_ack_o   <= 1'b0;
      sys_err_o   <= 1'b0;
      sys_rdata_o <= '0;
`ifdef SYS_BUS_TIMEOUT_EN
      cnt         <= '0;
`endif
    end else begin
      // Strobes and the upstream response are single-cycle pulses.
      slv_wen_o   <= '0;
      slv_ren_o   <= '0;
      sys_ack_o   <= 1'b0;
      sys_err_o   <= 1'b0;
      sys_rdata_o <= '0;
      case (state)
        IDLE: begin
          if (sys_wen_i || sys_ren_i) begin
            slv_addr_o  <= sys_addr_i;
            slv_wdata_o <= sys_wdata_i;
            slv_sel_o   <= sys_sel_i;
            idx         <= req_idx;
            is_wr       <= sys_wen_i;
            if (SLV_MASK[req_idx]) begin
              if (sys_wen_i) slv_wen_o[req_idx] <= 1'b1;
              else           slv_ren_o[req_idx] <= 1'b1;
              state <= BUSY;
`ifdef SYS_BUS_TIMEOUT_EN
              cnt   <= '0;
`endif
            end else begin
              sys_ack_o <= 1'b1;
              sys_err_o <= 1'b1;
              state     <= RESP;
            end
          end
        end
        BUSY: begin
          // A slave response wins over a timeout in the same cycle.
          if (sel_ack || sel_err) begin
            sys_ack_o   <= 1'b1;
            sys_err_o   <= sel_err;
            sys_rdata_o <= is_wr ? '0 : sel_rdata;
            state       <= RESP;
          end
`ifdef SYS_BUS_TIMEOUT_EN
          else if (cnt == CW'(TMO_CYC - 1)) begin
            sys_ack_o <= 1'b1;
            sys_err_o <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_bus_interconnect.sv
// Directed bench for sys_bus_interconnect (8 slaves, slave 7 unmapped).
module tb_sys_bus_interconnect;

  localparam int DW = 32;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   sys_addr;
  logic [DW-1:0] sys_wdata;
  logic [3:0]    sys_sel;
  logic          sys_wen;
  logic          sys_ren;
  logic [DW-1:0] sys_rdata;
  logic          sys_err;
  logic          sys_ack;
  logic [31:0]   slv_addr;
  logic [DW-1:0] slv_wdata;
  logic [3:0]    slv_sel;
  logic [N-1:0]  slv_wen;
  logic [N-1:0]  slv_ren;
  logic [N*DW-1:0] slv_rdata;
  logic [N-1:0]  slv_err;
  logic [N-1:0]  slv_ack;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sys_bus_interconnect #(
    .SYS_DW   (32),
    .SYS_AW   (32),
    .SLV_LOG2 (3),
    .SEL_LSB  (20),
    .SLV_MASK (8'h7F),
    .TMO_CYC  (16)
  ) dut (
    .sys_clk_i   (clk),
    .sys_rst_i   (rst),
    .sys_addr_i  (sys_addr),
    .sys_wdata_i (sys_wdata),
    .sys_sel_i   (sys_sel),
    .sys_wen_i   (sys_wen),
    .sys_ren_i   (sys_ren),
    .sys_rdata_o (sys_rdata),
    .sys_err_o   (sys_err),
    .sys_ack_o   (sys_ack),
    .slv_addr_o  (slv_addr),
    .slv_wdata_o (slv_wdata),
    .slv_sel_o   (slv_sel),
    .slv_wen_o   (slv_wen),
    .slv_ren_o   (slv_ren),
    .slv_rdata_i (slv_rdata),
    .slv_err_i   (slv_err),
    .slv_ack_i   (slv_ack)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_wen"},   32'(slv_wen),  32'h0);
    check({tag, "_ren"},   32'(slv_ren),  32'h0);
    check({tag, "_ack"},   32'(sys_ack),  32'h0);
    check({tag, "_err"},   32'(sys_err),  32'h0);
    check({tag, "_rdata"}, sys_rdata,     32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sys_addr = 32'h0030_0004; sys_wdata = 32'h1111_2222; sys_sel = 4'hF;
    sys_wen = 1'b1; sys_ren = 1'b0;
    slv_ack = '0; slv_err = '0; slv_rdata = '0;
    slv_rdata[1*DW +: DW] = 32'hCAFE_F00D;
    slv_rdata[3*DW +: DW] = 32'hAAAA_5555;
    slv_rdata[5*DW +: DW] = 32'h1234_5678;
    slv_rdata[6*DW +: DW] = 32'h6666_0006;
    slv_rdata[7*DW +: DW] = 32'hFFFF_FFFF;

    // Reset: strobes on the bus must not leak through.
    repeat (3) tick();
    check_quiet("rst");
    check("rst_addr",  slv_addr,         32'h0);
    check("rst_wdata", slv_wdata,        32'h0);
    check("rst_sel",   32'(slv_sel),     32'h0);
    sys_wen = 1'b0; rst = 1'b0;
    tick();

    // Write to slave 3, ack two cycles after the strobe.
    sys_addr = 32'h0030_0004; sys_wdata = 32'hDEAD_BEEF; sys_sel = 4'hC; sys_wen = 1'b1;
    tick(); sys_wen = 1'b0;
    check("wr_strobe", 32'(slv_wen), 32'h08);
    check("wr_ren",    32'(slv_ren), 32'h0);
    check("wr_wdata",  slv_wdata,    32'hDEAD_BEEF);
    check("wr_addr",   slv_addr,     32'h0030_0004);
    check("wr_sel",    32'(slv_sel), 32'hC);
    check("wr_noack",  32'(sys_ack), 32'h0);
    tick();
    check("wr_strobe_once", 32'(slv_wen), 32'h0);
    tick(); slv_ack = 8'h08;
    check("wr_wait", 32'(sys_ack), 32'h0);
    tick(); slv_ack = '0;
    check("wr_ack",   32'(sys_ack), 32'h1);
    check("wr_err",   32'(sys_err), 32'h0);
    check("wr_rdata", sys_rdata,    32'h0);
    tick();
    check("wr_ack_once", 32'(sys_ack), 32'h0);
    check("wr_hold",     slv_wdata,    32'hDEAD_BEEF);

    // Read from slave 5, combinational ack in the strobe cycle.
    sys_addr = 32'h0050_0000; sys_ren = 1'b1;
    tick(); sys_ren = 1'b0;
    check("rd_strobe", 32'(slv_ren), 32'h20);
    slv_ack = 8'h20;
    tick(); slv_ack = '0;
    check("rd_ack",   32'(sys_ack), 32'h1);
    check("rd_err",   32'(sys_err), 32'h0);
    check("rd_rdata", sys_rdata,    32'h1234_5678);
    sys_ren = 1'b1;                      // arrives in RESP: dropped
    tick();
    check("resp_drop_ren", 32'(slv_ren), 32'h0);
    check("resp_drop_ack", 32'(sys_ack), 32'h0);
    sys_addr = 32'h0070_0000;            // back-to-back, unmapped slave 7
    tick(); sys_ren = 1'b0;
    check("unmap_ren",   32'(slv_ren), 32'h0);
    check("unmap_ack",   32'(sys_ack), 32'h1);
    check("unmap_err",   32'(sys_err), 32'h1);
    check("unmap_rdata", sys_rdata,    32'h0);
    tick();
    check_quiet("unmap_after");

    // Both strobes to slave 2: write wins. Foreign acks and upstream wen during BUSY ignored.
    sys_addr = 32'h0020_0000; sys_wdata = 32'h0BAD_F00D; sys_wen = 1'b1; sys_ren = 1'b1;
    tick(); sys_ren = 1'b0;
    check("both_wen", 32'(slv_wen), 32'h04);
    check("both_ren", 32'(slv_ren), 32'h0);
    sys_addr = 32'h0040_0000; sys_wdata = 32'h0000_0055;
    slv_ack = 8'h10; slv_err = 8'h10;
    tick();
    check_quiet("busy1");
    check("busy_addr_hold",  slv_addr,  32'h0020_0000);
    check("busy_wdata_hold", slv_wdata, 32'h0BAD_F00D);
    tick();
    check_quiet("busy2");
    sys_wen = 1'b0; slv_ack = '0; slv_err = 8'h04;
    tick(); slv_err = '0;
    check("slverr_ack",   32'(sys_ack), 32'h1);
    check("slverr_err",   32'(sys_err), 32'h1);
    check("slverr_rdata", sys_rdata,    32'h0);
    tick();
    check_quiet("slverr_after");

    // Reset mid-BUSY for one cycle, late ack ignored, next request served.
    sys_addr = 32'h0030_0000; sys_ren = 1'b1;
    tick(); sys_ren = 1'b0;
    check("abort_strobe", 32'(slv_ren), 32'h08);
    rst = 1'b1;
    tick(); rst = 1'b0;
    check_quiet("abort_rst");
    check("abort_addr", slv_addr, 32'h0);
    slv_ack = 8'h08;
    tick(); slv_ack = '0;
    check_quiet("abort_late");
    sys_addr = 32'h0060_0010; sys_ren = 1'b1;
    tick(); sys_ren = 1'b0;
    check("post_rst_strobe", 32'(slv_ren), 32'h40);
    slv_ack = 8'h40;
    tick(); slv_ack = '0;
    check("post_rst_ack",   32'(sys_ack), 32'h1);
    check("post_rst_rdata", sys_rdata,    32'h6666_0006);
    tick();

`ifdef SYS_BUS_TIMEOUT_EN
    // Silent slave 1: error ack 16 cycles after BUSY entry; a later ack is ignored.
    sys_addr = 32'h0010_0000; sys_ren = 1'b1;
    tick(); sys_ren = 1'b0;
    check("tmo_strobe", 32'(slv_ren), 32'h02);
    for (int k = 2; k <= 16; k++) begin
      tick();
      check("tmo_wait", 32'(sys_ack), 32'h0);
    end
    tick();
    check("tmo_ack",   32'(sys_ack), 32'h1);
    check("tmo_err",   32'(sys_err), 32'h1);
    check("tmo_rdata", sys_rdata,    32'h0);
    repeat (3) tick();
    slv_ack = 8'h02;
    tick(); slv_ack = '0;
    check_quiet("tmo_late");
    // Response in the timeout cycle wins.
    sys_ren = 1'b1;
    tick(); sys_ren = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      tick();
      check("tmo_pri_wait", 32'(sys_ack), 32'h0);
    end
    slv_ack = 8'h02;
    tick(); slv_ack = '0;
    check("tmo_pri_ack",   32'(sys_ack), 32'h1);
    check("tmo_pri_err",   32'(sys_err), 32'h0);
    check("tmo_pri_rdata", sys_rdata,    32'hCAFE_F00D);
    tick();
`else
    // No timeout: BUSY waits for the slave.
    sys_addr = 32'h0010_0000; sys_ren = 1'b1;
    tick(); sys_ren = 1'b0;
    check("wait_strobe", 32'(slv_ren), 32'h02);
    for (int k = 0; k < 30; k++) begin
      tick();
      check("wait_noack", 32'(sys_ack), 32'h0);
    end
    slv_ack = 8'h02;
    tick(); slv_ack = '0;
    check("wait_ack",   32'(sys_ack), 32'h1);
    check("wait_rdata", sys_rdata,    32'hCAFE_F00D);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
